// File: rtl/coin_accumulator.sv
// coin_accumulator
//   Counts nickels, dimes and quarters into a running credit (cents).
//   When the credit reaches PRICE it pulses vend. Any overpayment or a
//   cancel refund is offered as a change amount on a valid/ready handshake.
//
// Parameters:
//   PRICE      - item price in cents (multiple of 5, 5..MAX_CREDIT)
//   MAX_CREDIT - highest credit accepted (multiple of 5, <= 70)
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   coin_valid    one-cycle pulse per inserted coin
//   coin_type     00 nickel, 01 dime, 10 quarter, 11 invalid
//   cancel        one-cycle refund request
//   change_ready  downstream accepts the change value
//   credit        accumulated credit in cents
//   vend          one-cycle pulse: item paid
//   change        change/refund amount, valid while change_valid is high
//   change_valid  change offer pending
//   coin_reject   one-cycle pulse: sampled coin returned without credit
//   busy          high while a change offer is pending
module coin_accumulator #(
  parameter int unsigned PRICE      = 50,
  parameter int unsigned MAX_CREDIT = 70
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       change_ready,
  output logic [7:0] credit,
  output logic       vend,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);

  typedef enum logic {
    ACCEPT = 1'b0,
    CHANGE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       vend_q, vend_d;
  logic [7:0] change_q, change_d;
  logic       change_valid_q, change_valid_d;
  logic       coin_reject_q, coin_reject_d;

  logic [7:0] coin_val;
  logic       coin_ok;
  logic [7:0] sum;

  always_comb begin
    coin_val = '0;
    coin_ok  = 1'b1;
    case (coin_type)
      2'b00:   coin_val = 8'd5;
      2'b01:   coin_val = 8'd10;
      2'b10:   coin_val = 8'd25;
      default: coin_ok  = 1'b0;
    endcase
  end

  // credit <= 70 and coin <= 25, so the 8-bit sum cannot wrap
  assign sum = credit_q + coin_val;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    vend_d         = 1'b0;
    change_d       = change_q;
    change_valid_d = change_valid_q;
    coin_reject_d  = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (cancel) begin
          // a coin arriving with cancel is always returned
          coin_reject_d = coin_valid;
          if (credit_q != '0) begin
            change_d       = credit_q;
            change_valid_d = 1'b1;
            credit_d       = '0;
            state_d        = CHANGE;
          end
        end else if (coin_valid) begin
          if (!coin_ok || sum > MAX_C) begin
            coin_reject_d = 1'b1;
          end else if (sum < PRICE_C) begin
            credit_d = sum;
          end else if (sum == PRICE_C) begin
            vend_d   = 1'b1;
            credit_d = '0;
          end else begin
            vend_d         = 1'b1;
            credit_d       = '0;
            change_d       = sum - PRICE_C;
            change_valid_d = 1'b1;
            state_d        = CHANGE;
          end
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ready) begin
          change_d       = '0;
          change_valid_d = 1'b0;
          state_d        = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACCEPT;
      credit_q       <= '0;
      vend_q         <= 1'b0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      vend_q         <= vend_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign credit       = credit_q;
  assign vend         = vend_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = (state_q == CHANGE);

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Coin-acceptance front end for the vending datapath. It counts inserted quarters, dimes and nickels into a running credit in cents and fires a vend pulse once the credit reaches the item price. It then presents the change amount, always a multiple of 5 and below 75, on a valid/ready handshake to the downstream coin parser that splits it into Q/D/N counts. It also handles cancel and refund, and rejects coins it cannot accept.

## Interface
Parameters:
- PRICE, default 50: item price in cents. Multiple of 5, 5 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, default 70: highest credit the block will accept. Multiple of 5, ≤ 70, so every change amount stays below 75.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle pulse per inserted coin
- coin_type  in  2  coin code, sampled with coin_valid: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 invalid
- cancel  in  1  one-cycle refund request
- change_ready  in  1  downstream parser accepts the change value
- credit  out  8  current accumulated credit in cents
- vend  out  1  one-cycle pulse: item paid
- change  out  8  change or refund amount in cents; valid while change_valid is high
- change_valid  out  1  change offer pending
- coin_reject  out  1  one-cycle pulse: the sampled coin was returned, no credit given
- busy  out  1  high in the CHANGE state

## Operation
- Two states:
  - ACCEPT is the reset state.
  - CHANGE means a change offer is pending.
- All outputs are registered. Every response appears on the cycle after the inputs are sampled.
- Reset values: credit=0, vend=0, change=0, change_valid=0, coin_reject=0, busy=0, state ACCEPT.
- Behaviour in ACCEPT, evaluated in priority order:
  1. **cancel=1.** If coin_valid is also high, that coin is rejected (coin_reject=1). If credit>0: change=credit, change_valid=1, credit=0, go to CHANGE, no vend. If credit=0: no action apart from any reject.
  2. **coin_valid=1 with coin_type=11.** coin_reject=1, credit unchanged.
  3. **coin_valid=1 with value v, where credit+v > MAX_CREDIT.** coin_reject=1, credit unchanged.
  4. **coin_valid=1 with value v, sum s=credit+v.**
     - s < PRICE: credit=s.
     - s = PRICE: vend=1, credit=0, stay in ACCEPT, change_valid stays 0.
     - s > PRICE: vend=1, credit=0, change=s−PRICE, change_valid=1, go to CHANGE.
- Behaviour in CHANGE:
  - change and change_valid are held stable until change_ready is sampled high.
  - On the cycle after change_ready is sampled high: change_valid=0, change=0, go to ACCEPT.
  - Every coin_valid is rejected with coin_reject=1.
  - cancel is ignored.
  - change_ready is ignored while in ACCEPT.
- Arithmetic: credit ≤ 70 and v ≤ 25, so the 8-bit sum cannot overflow. change ≤ MAX_CREDIT−5.
- busy equals (state == CHANGE).

## Timing
- Coin to credit update: 1 cycle.
- Coin to vend / change_valid: 1 cycle. vend and change_valid rise in the same cycle.
- Handshake: a transfer occurs when change_valid and change_ready are both high at a rising edge. change_valid falls on the next cycle. The earliest new offer comes 1 cycle after that, since the block must be back in ACCEPT to take a coin.
- vend and coin_reject last exactly one cycle each.
- Back-to-back coin_valid pulses on consecutive cycles are each processed against the already-updated credit.
- Reset at any point, including during CHANGE: all outputs return to their reset values on the next cycle. A pending change offer is discarded.

## Test plan
Defaults PRICE=50, MAX_CREDIT=70 unless noted.
1. **Exact payment.** Quarter, then quarter.
   - credit reads 25.
   - Then vend=1 for one cycle, credit=0, change_valid stays 0.
2. **Overpayment with held handshake.** Dime ×3, then quarter.
   - credit goes 10 → 20 → 30.
   - Then vend=1, change=5, change_valid=1.
   - Hold change_ready=0 for 3 cycles: change stays 5.
   - Assert change_ready: change_valid=0 and busy=0 on the next cycle.
3. **Refund, then coin during CHANGE.** Nickel, dime, cancel.
   - change=15, change_valid=1, vend stays 0, credit=0.
   - Quarter while change_valid=1: coin_reject=1, credit stays 0.
4. **Invalid coin and empty cancel.**
   - coin_type=11: coin_reject=1, credit unchanged.
   - cancel at credit 0: change_valid stays 0, state stays ACCEPT.
5. **Simultaneous cancel and coin.** Credit 10, then cancel and a quarter in the same cycle.
   - coin_reject=1, change=10, vend=0.
6. **Credit cap and reset mid-offer.** PRICE=70, MAX_CREDIT=70.
   - Quarter ×2 gives credit 50. A third quarter: coin_reject=1, credit stays 50.
   - Dime ×2: vend=1, credit=0, no change offer.
   - Separately, reset while in CHANGE: next cycle change_valid=0, change=0, credit=0, busy=0.
